// File: rtl/dct8_mcm_pkg.sv
// Shared constants and helpers for the 8-point DCT multiplier stage.
package dct8_mcm_pkg;
  localparam int IW = 26;
  localparam int OW = 16;
  localparam int MW = 36;

  typedef logic signed [MW-1:0] acc_t;

  localparam acc_t C64 = acc_t'(64);
  localparam acc_t C83 = acc_t'(83);
  localparam acc_t C36 = acc_t'(36);
  localparam acc_t C89 = acc_t'(89);
  localparam acc_t C75 = acc_t'(75);
  localparam acc_t C50 = acc_t'(50);
  localparam acc_t C18 = acc_t'(18);

  function automatic acc_t sx(input logic signed [IW-1:0] v);
    return {{(MW-IW){v[IW-1]}}, v};
  endfunction
endpackage

// File: rtl/dct8_round_sat.sv
// Registered round-half-up, arithmetic shift and saturation to the output width.
module dct8_round_sat
  import dct8_mcm_pkg::*;
#(
  parameter int SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  acc_t                 d,
  output logic signed [OW-1:0] q
);
  localparam acc_t RND  = acc_t'(1) <<< (SHIFT - 1);
  localparam acc_t MAXV = acc_t'((2 ** (OW - 1)) - 1);
  localparam acc_t MINV = acc_t'(-(2 ** (OW - 1)));

  acc_t sh;

  always_comb sh = (d + RND) >>> SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      if (sh > MAXV)      q <= MAXV[OW-1:0];
      else if (sh < MINV) q <= MINV[OW-1:0];
      else                q <= sh[OW-1:0];
    end
  end
endmodule

// File: rtl/dct8_mcm.sv
// Constant-multiplier core of the 8-point DCT: pre-sums, products, round/saturate.
module dct8_mcm
  import dct8_mcm_pkg::*;
#(
  parameter int SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  input  logic signed [IW-1:0] i_0,
  input  logic signed [IW-1:0] i_1,
  input  logic signed [IW-1:0] i_2,
  input  logic signed [IW-1:0] i_3,
  input  logic signed [IW-1:0] i_4,
  input  logic signed [IW-1:0] i_5,
  input  logic signed [IW-1:0] i_6,
  input  logic signed [IW-1:0] i_7,
  output logic                 o_valid,
  output logic signed [OW-1:0] o_0,
  output logic signed [OW-1:0] o_1,
  output logic signed [OW-1:0] o_2,
  output logic signed [OW-1:0] o_3,
  output logic signed [OW-1:0] o_4,
  output logic signed [OW-1:0] o_5,
  output logic signed [OW-1:0] o_6,
  output logic signed [OW-1:0] o_7,
  output logic [2:0]           o_row,
  output logic                 o_last
);
  logic v1, v2, v3;
  logic [2:0] row_q;
  acc_t e0, e1, d0, d1, od0, od1, od2, od3;
  acc_t dst [8];
  logic signed [OW-1:0] y [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      row_q <= '0;
    end else begin
      v1 <= i_valid;
      v2 <= v1;
      v3 <= v2;
      if (v3) row_q <= row_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      d0  <= '0;
      d1  <= '0;
      od0 <= '0;
      od1 <= '0;
      od2 <= '0;
      od3 <= '0;
    end else if (i_valid) begin
      e0  <= sx(i_0) + sx(i_3);
      e1  <= sx(i_1) + sx(i_2);
      d0  <= sx(i_0) - sx(i_3);
      d1  <= sx(i_1) - sx(i_2);
      od0 <= sx(i_7);
      od1 <= sx(i_6);
      od2 <= sx(i_5);
      od3 <= sx(i_4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst <= '{default: '0};
    end else if (v1) begin
      dst[0] <= C64 * (e0 + e1);
      dst[4] <= C64 * (e0 - e1);
      dst[2] <= C83 * d0 + C36 * d1;
      dst[6] <= C36 * d0 - C83 * d1;
      dst[1] <= C89 * od0 + C75 * od1 + C50 * od2 + C18 * od3;
      dst[3] <= C75 * od0 - C18 * od1 - C89 * od2 - C50 * od3;
      dst[5] <= C50 * od0 - C89 * od1 + C18 * od2 + C75 * od3;
      dst[7] <= C18 * od0 - C50 * od1 + C75 * od2 - C89 * od3;
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_rs
    dct8_round_sat #(.SHIFT(SHIFT)) u_rs (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (v2),
      .d    (dst[g]),
      .q    (y[g])
    );
  end

  // row_q counts rows already presented, so it labels the row now on the outputs
  assign o_valid = v3;
  assign o_row   = row_q;
  assign o_last  = v3 && (row_q == 3'd7);
  assign o_0 = y[0];
  assign o_1 = y[1];
  assign o_2 = y[2];
  assign o_3 = y[3];
  assign o_4 = y[4];
  assign o_5 = y[5];
  assign o_6 = y[6];
  assign o_7 = y[7];
endmodule

// File: doc/dct8_mcm.md
DCT8_MCM -- requirements
Module: dct8_mcm

Interface
REQ-001 Parameter: SHIFT, default 2, right-shift applied to every output with rounding; legal range 1..12.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 i_valid  input  1  row of butterfly results present on i_0..i_7 this cycle.
REQ-005 i_0..i_3  input  26 each, signed  8-point butterfly sums: i_k = x[k] + x[7-k].
REQ-006 i_4..i_7  input  26 each, signed  butterfly differences: i_4 = x3-x4, i_5 = x2-x5, i_6 = x1-x6, i_7 = x0-x7.
REQ-007 o_valid  output  1  o_0..o_7 hold a transformed row.
REQ-008 o_0..o_7  output  16 each, signed  DCT coefficients dst0..dst7, rounded, shifted and saturated.
REQ-009 o_row  output  3  index of the current output row within its 8-row block.
REQ-010 o_last  output  1  high with o_valid when o_row = 7.

Function
REQ-011 Even part: e0 = i_0+i_3, e1 = i_1+i_2, d0 = i_0-i_3, d1 = i_1-i_2.
REQ-012 dst0 = 64(e0+e1); dst4 = 64(e0-e1); dst2 = 83d0+36d1; dst6 = 36d0-83d1.
REQ-013 Odd part, with O0 = i_7, O1 = i_6, O2 = i_5, O3 = i_4: dst1 = 89O0+75O1+50O2+18O3; dst3 = 75O0-18O1-89O2-50O3; dst5 = 50O0-89O1+18O2+75O3; dst7 = 18O0-50O1+75O2-89O3.
REQ-014 Intermediate arithmetic: signed, at least 36 bits; no intermediate overflow or truncation for any 26-bit input.
REQ-015 Output conversion: y = (dst + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, floor), then saturate to [-32768, 32767].
REQ-016 Pipeline: three register stages.
- Stage 1: even/odd pre-sums.
- Stage 2: products and sums.
- Stage 3: round and saturate.
REQ-017 Latency: exactly 3 cycles from i_valid sampled high to o_valid high with the corresponding row; throughput one row per cycle; no backpressure.
REQ-018 o_valid is i_valid delayed by 3 cycles.
REQ-019 Data registers do not update on invalid cycles: o_0..o_7 hold their last valid values while o_valid = 0.
REQ-020 o_row increments by 1 on each cycle o_valid is high and wraps 7 -> 0; gaps in o_valid hold the count.
REQ-021 o_row, as presented, labels the row currently on the outputs: it equals the number of rows already output modulo 8.
REQ-022 Back-to-back and gapped i_valid patterns produce identical per-row results.

Reset
REQ-023 While rst_n = 0: o_valid = 0, o_last = 0, o_row = 0, o_0..o_7 = 0, all pipeline valid bits = 0; takes effect without a clock edge.
REQ-024 Rows in flight when reset asserts are discarded; none appear after rst_n returns high.
REQ-025 After release, the first row output has o_row = 0.

Structure
REQ-026 Shared tq package holds: coefficient constants 64, 83, 36, 89, 75, 50, 18; input width 26; output width 16; intermediate width 36.
REQ-027 One sub-module, dct8_round_sat (round, shift, saturate, register), instantiated eight times.
REQ-028 The block connects directly to the outputs of the 8-point butterfly stage; it contains no butterfly of its own beyond REQ-011.

Verification
REQ-029 Reset: rst_n low mid-simulation -> all outputs 0 immediately, without a clock edge.
REQ-030 DC row, SHIFT = 2: i_0..i_3 = 100, i_4..i_7 = 0 -> 3 cycles later o_valid = 1, o_0 = 6400, o_1..o_7 = 0.
REQ-031 Odd impulse, SHIFT = 2:
- i_7 = 1, others 0 -> o_1 = 22, o_3 = 19, o_5 = 13, o_7 = 5, rest 0.
- i_7 = -1 -> o_1 = -22.
REQ-032 Saturation: i_0..i_3 = 2^24 -> o_0 = 32767; i_0..i_3 = -2^24 -> o_0 = -32768.
REQ-033 Stream: 10 consecutive valid rows, one gap cycle after row 4 -> o_row sequence 0..7,0,1; o_last only on the 8th row; no row lost or duplicated.
REQ-034 Reset mid-flight: rst_n low 1 cycle with 2 rows in the pipeline -> no o_valid pulse afterwards until new input arrives; first new row has o_row = 0.
